// File: rtl/input_scaler_feeder_if.sv
// -----------------------------------------------------------------------------
// input_scaler_feeder_if
// Bundles the loader-side write port and the layer-side stream port of the
// input scaler feeder.
//   master : producer / observer side (drives WR_EN, WR_DATA)
//   slave  : feeder side (drives the status flags and the scalar stream)
// Signals:
//   WR_EN, WR_DATA          push request and scalar from the loader
//   FULL, OVERFLOW          buffer status (OVERFLOW is sticky)
//   INPUT_SCALER            registered scalar to the layer
//   SCALER_VALID            INPUT_SCALER carries a frame element
//   FRAME_LAST              last element of a frame
//   LAYER_RESET             registered reset to the layer
// -----------------------------------------------------------------------------
interface input_scaler_feeder_if #(
   parameter int DATA_W = 34
);
   logic              WR_EN;
   logic [DATA_W-1:0] WR_DATA;
   logic              FULL;
   logic              OVERFLOW;
   logic [DATA_W-1:0] INPUT_SCALER;
   logic              SCALER_VALID;
   logic              FRAME_LAST;
   logic              LAYER_RESET;

   modport master (
      output WR_EN, WR_DATA,
      input  FULL, OVERFLOW, INPUT_SCALER, SCALER_VALID, FRAME_LAST, LAYER_RESET
   );

   modport slave (
      input  WR_EN, WR_DATA,
      output FULL, OVERFLOW, INPUT_SCALER, SCALER_VALID, FRAME_LAST, LAYER_RESET
   );
endinterface

// File: rtl/input_scaler_feeder.sv
// -----------------------------------------------------------------------------
// input_scaler_feeder
// Buffers net-input scalars (unknowns followed by nonlinear terms) and streams
// them one per cycle to the linear layer. A frame of FRAME_LEN elements is
// launched only once the whole frame is buffered, because the layer cannot
// stall. While no frame is streaming, LAYER_RESET is held high so the layer
// realigns its weight pointer and accumulators at every frame start.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous active-high reset (discards buffered data)
//   bus    input_scaler_feeder_if.slave (write port, status, scalar stream)
// Parameter constraints: EXTRA_BITS is 0 or 2; FIFO_DEPTH is a power of two,
// at least 2, and >= NUM_UNKNOWNS + NUM_NONLIN.
// -----------------------------------------------------------------------------
module input_scaler_feeder #(
   parameter int NUM_UNKNOWNS = 2,
   parameter int NUM_NONLIN   = 1,
   parameter int BIT_WIDTH    = 32,
   parameter int EXTRA_BITS   = 2,
   parameter int FIFO_DEPTH   = 8
) (
   input logic                  CLK,
   input logic                  RESET,
   input_scaler_feeder_if.slave bus
);

   localparam int FRAME_LEN = NUM_UNKNOWNS + NUM_NONLIN;
   localparam int DW        = BIT_WIDTH + EXTRA_BITS;
   localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW        = $clog2(FIFO_DEPTH) + 1;
   localparam int IW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CW-1:0] FL_CNT    = CW'(FRAME_LEN);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
   localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
   localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [DW-1:0] DATA_ZERO = DW'(0);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   logic [DW-1:0] r_mem [FIFO_DEPTH];

   state_t        r_state,       w_state_nxt;
   logic [IW-1:0] r_elem_idx,    w_elem_idx_nxt;
   logic [AW-1:0] r_wr_ptr,      w_wr_ptr_nxt;
   logic [AW-1:0] r_rd_ptr,      w_rd_ptr_nxt;
   logic [CW-1:0] r_count,       w_count_nxt;
   logic [DW-1:0] r_scaler,      w_scaler_nxt;
   logic          r_valid,       w_valid_nxt;
   logic          r_last,        w_last_nxt;
   logic          r_full,        w_full_nxt;
   logic          r_overflow,    w_overflow_nxt;
   logic          r_layer_reset, w_layer_reset_nxt;

   logic w_push;
   logic w_drop;
   logic w_pop;
   logic w_frame_ready;

   // Next-state, pop decision, pointer/count and output register inputs
   always_comb begin
      w_push            = bus.WR_EN & ~r_full;
      // A push against a full buffer is dropped even if a pop frees a slot
      w_drop            = bus.WR_EN & r_full;
      // Launch decisions use the pre-edge count only; a same-cycle push
      // never completes a frame early.
      w_frame_ready     = (r_count >= FL_CNT);
      w_pop             = 1'b0;
      w_state_nxt       = r_state;
      w_elem_idx_nxt    = r_elem_idx;

      case (r_state)
         ST_IDLE: begin
            if (w_frame_ready) begin
               w_pop          = 1'b1;
               w_state_nxt    = ST_STREAM;
               w_elem_idx_nxt = IDX_ZERO;
            end else begin
               w_state_nxt    = ST_IDLE;
            end
         end
         ST_STREAM: begin
            // Mid-frame elements are guaranteed buffered: the frame was
            // launched with all of them present.
            if (r_elem_idx != LAST_IDX) begin
               w_pop          = 1'b1;
               w_elem_idx_nxt = r_elem_idx + IDX_ONE;
            end else if (w_frame_ready) begin
               w_pop          = 1'b1;
               w_elem_idx_nxt = IDX_ZERO;
            end else begin
               w_state_nxt    = ST_IDLE;
               w_elem_idx_nxt = IDX_ZERO;
            end
         end
         default: begin
            w_state_nxt    = ST_IDLE;
            w_elem_idx_nxt = IDX_ZERO;
         end
      endcase

      w_wr_ptr_nxt   = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
      w_rd_ptr_nxt   = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
      w_count_nxt    = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
      w_full_nxt     = (w_count_nxt == DEPTH_CNT);
      w_overflow_nxt = r_overflow | w_drop;

      if (w_pop) begin
         w_scaler_nxt      = r_mem[r_rd_ptr];
         w_valid_nxt       = 1'b1;
         w_last_nxt        = (w_elem_idx_nxt == LAST_IDX);
         w_layer_reset_nxt = 1'b0;
      end else begin
         w_scaler_nxt      = DATA_ZERO;
         w_valid_nxt       = 1'b0;
         w_last_nxt        = 1'b0;
         w_layer_reset_nxt = 1'b1;
      end
   end

   // State, pointer, count and output registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state       <= ST_IDLE;
         r_elem_idx    <= IDX_ZERO;
         r_wr_ptr      <= {AW{1'b0}};
         r_rd_ptr      <= {AW{1'b0}};
         r_count       <= {CW{1'b0}};
         r_scaler      <= DATA_ZERO;
         r_valid       <= 1'b0;
         r_last        <= 1'b0;
         r_full        <= 1'b0;
         r_overflow    <= 1'b0;
         r_layer_reset <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_elem_idx    <= w_elem_idx_nxt;
         r_wr_ptr      <= w_wr_ptr_nxt;
         r_rd_ptr      <= w_rd_ptr_nxt;
         r_count       <= w_count_nxt;
         r_scaler      <= w_scaler_nxt;
         r_valid       <= w_valid_nxt;
         r_last        <= w_last_nxt;
         r_full        <= w_full_nxt;
         r_overflow    <= w_overflow_nxt;
         r_layer_reset <= w_layer_reset_nxt;
      end
   end

   // Buffer storage; contents are invalidated by the pointers, not cleared
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.WR_DATA;
      end
   end

   assign bus.INPUT_SCALER = r_scaler;
   assign bus.SCALER_VALID = r_valid;
   assign bus.FRAME_LAST   = r_last;
   assign bus.FULL         = r_full;
   assign bus.OVERFLOW     = r_overflow;
   assign bus.LAYER_RESET  = r_layer_reset;

endmodule

// File: tb/tb_input_scaler_feeder.sv
// -----------------------------------------------------------------------------
// tb_input_scaler_feeder
// Self-checking bench. DUT u1 uses the default 3-element frame in an 8-deep
// buffer and is tracked every cycle by a queue-based reference model; DUT u2
// uses an 8-element frame in an 8-deep buffer to reach FULL and OVERFLOW.
// -----------------------------------------------------------------------------
module tb_input_scaler_feeder;

   localparam int FL    = 3;
   localparam int DEPTH = 8;
   localparam int DW    = 34;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   input_scaler_feeder_if #(.DATA_W(DW)) b1 ();
   input_scaler_feeder_if #(.DATA_W(DW)) b2 ();

   input_scaler_feeder #(
      .NUM_UNKNOWNS(2), .NUM_NONLIN(1), .BIT_WIDTH(32), .EXTRA_BITS(2), .FIFO_DEPTH(8)
   ) u1 (.CLK(CLK), .RESET(RESET), .bus(b1));

   input_scaler_feeder #(
      .NUM_UNKNOWNS(7), .NUM_NONLIN(1), .BIT_WIDTH(32), .EXTRA_BITS(2), .FIFO_DEPTH(8)
   ) u2 (.CLK(CLK), .RESET(RESET), .bus(b2));

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_seen = 0;
   int n_last = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: a queue of buffered values plus the number of elements
   // still owed to the frame in flight.
   logic [DW-1:0] mq[$];
   int            left   = 0;
   logic [DW-1:0] m_data = '0;
   logic          m_valid = 1'b0;
   logic          m_last  = 1'b0;
   logic          m_lr    = 1'b1;
   logic          m_full  = 1'b0;
   logic          m_ovf   = 1'b0;

   always @(posedge CLK or posedge RESET) begin
      int pre;
      if (RESET) begin
         mq.delete();
         left = 0; m_data = '0; m_valid = 1'b0; m_last = 1'b0;
         m_lr = 1'b1; m_full = 1'b0; m_ovf = 1'b0;
      end else begin
         pre = mq.size();
         if (left == 0 && pre >= FL) left = FL;
         if (left > 0) begin
            m_data  = mq.pop_front();
            left    = left - 1;
            m_valid = 1'b1;
            m_last  = (left == 0);
            m_lr    = 1'b0;
         end else begin
            m_data = '0; m_valid = 1'b0; m_last = 1'b0; m_lr = 1'b1;
         end
         if (b1.WR_EN) begin
            if (pre == DEPTH) m_ovf = 1'b1;
            else              mq.push_back(b1.WR_DATA);
         end
         m_full = (mq.size() == DEPTH);
      end
   end

   // Every falling edge: compare u1 against the model
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("m_valid", b1.SCALER_VALID, m_valid);
         chk("m_data",  b1.INPUT_SCALER, m_data);
         chk("m_last",  b1.FRAME_LAST,   m_last);
         chk("m_lreset", b1.LAYER_RESET, m_lr);
         chk("m_full",  b1.FULL,         m_full);
         chk("m_ovf",   b1.OVERFLOW,     m_ovf);
         if (b1.SCALER_VALID) n_seen++;
         if (b1.FRAME_LAST)   n_last++;
      end
   end

   task automatic idle(input int n);
      b1.WR_EN = 1'b0;
      repeat (n) begin
         @(posedge CLK);
         @(negedge CLK);
      end
   endtask

   task automatic push1(input logic [DW-1:0] d);
      b1.WR_EN   = 1'b1;
      b1.WR_DATA = d;
      @(posedge CLK);
      @(negedge CLK);
      b1.WR_EN   = 1'b0;
   endtask

   task automatic reset_pulse_check(input string tag);
      #2 RESET = 1'b1;
      #1;
      chk({tag, "_valid"},  b1.SCALER_VALID, 1'b0);
      chk({tag, "_data"},   b1.INPUT_SCALER, 34'h0);
      chk({tag, "_last"},   b1.FRAME_LAST,   1'b0);
      chk({tag, "_lreset"}, b1.LAYER_RESET,  1'b1);
      chk({tag, "_full"},   b1.FULL,         1'b0);
      #1 RESET = 1'b0;
   endtask

   typedef struct {
      logic          we;
      logic [DW-1:0] d;
      logic          ev;
      logic [DW-1:0] ed;
      logic          el;
      logic          elr;
   } vec_t;

   vec_t tbl[7];

   initial begin
      logic [DW-1:0] va, vb, vc, rv, v2;
      int s0, l0, pushed;

      b1.WR_EN = 1'b0; b1.WR_DATA = '0;
      b2.WR_EN = 1'b0; b2.WR_DATA = '0;

      va = 34'h0_1234_5678;
      vb = 34'h2_89AB_CDEF;
      vc = 34'h3_FFFF_FFFF;
      //          we    d      valid data          last  lreset
      tbl[0] = '{1'b1, va,    1'b0, 34'h0,        1'b0, 1'b1};
      tbl[1] = '{1'b1, vb,    1'b0, 34'h0,        1'b0, 1'b1};
      tbl[2] = '{1'b1, vc,    1'b0, 34'h0,        1'b0, 1'b1};
      tbl[3] = '{1'b0, 34'h0, 1'b1, va,           1'b0, 1'b0};
      tbl[4] = '{1'b0, 34'h0, 1'b1, vb,           1'b0, 1'b0};
      tbl[5] = '{1'b0, 34'h0, 1'b1, vc,           1'b1, 1'b0};
      tbl[6] = '{1'b0, 34'h0, 1'b0, 34'h0,        1'b0, 1'b1};

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_valid",  b1.SCALER_VALID, 1'b0);
      chk("rst_data",   b1.INPUT_SCALER, 34'h0);
      chk("rst_last",   b1.FRAME_LAST,   1'b0);
      chk("rst_lreset", b1.LAYER_RESET,  1'b1);
      chk("rst_full",   b1.FULL,         1'b0);
      chk("rst_ovf",    b1.OVERFLOW,     1'b0);
      chk("rst2_lreset", b2.LAYER_RESET, 1'b1);
      RESET  = 1'b0;
      chk_en = 1'b1;

      // Single frame, table driven
      for (int i = 0; i < 7; i++) begin
         b1.WR_EN   = tbl[i].we;
         b1.WR_DATA = tbl[i].d;
         @(posedge CLK);
         @(negedge CLK);
         chk($sformatf("tbl%0d_valid", i),  b1.SCALER_VALID, tbl[i].ev);
         chk($sformatf("tbl%0d_data", i),   b1.INPUT_SCALER, tbl[i].ed);
         chk($sformatf("tbl%0d_last", i),   b1.FRAME_LAST,   tbl[i].el);
         chk($sformatf("tbl%0d_lreset", i), b1.LAYER_RESET,  tbl[i].elr);
      end
      b1.WR_EN = 1'b0;

      // Reset in the middle of a streaming frame
      push1(34'h0_0000_0011); push1(34'h0_0000_0022); push1(34'h0_0000_0033);
      idle(1);
      chk("pre_rst_valid", b1.SCALER_VALID, 1'b1);
      reset_pulse_check("rst_mid");

      // Reset with two elements buffered; FIFO must come back empty
      push1(34'h0_0000_0044); push1(34'h0_0000_0055);
      idle(3);
      reset_pulse_check("rst_buf");
      push1(34'h1_0000_0001); push1(34'h1_0000_0002);
      idle(6);
      chk("partial_valid",  b1.SCALER_VALID, 1'b0);
      chk("partial_lreset", b1.LAYER_RESET,  1'b1);

      // Third element completes the frame; launch one edge later
      push1(34'h1_0000_0003);
      chk("launch_wait", b1.SCALER_VALID, 1'b0);
      idle(1);
      chk("launch_valid", b1.SCALER_VALID, 1'b1);
      chk("launch_data",  b1.INPUT_SCALER, 34'h1_0000_0001);
      idle(4);

      // Back-to-back frames
      s0 = n_seen; l0 = n_last;
      for (int i = 0; i < 6; i++) push1(34'h2_0000_0000 + 34'(i));
      idle(6);
      chk("b2b_valid_cycles", 64'(n_seen - s0), 64'd6);
      chk("b2b_last_count",   64'(n_last - l0), 64'd2);

      // Overflow on the 8-element-frame instance
      for (int i = 0; i < 9; i++) begin
         b2.WR_EN   = 1'b1;
         b2.WR_DATA = 34'h1_0000_0000 + 34'(i);
         @(posedge CLK);
         @(negedge CLK);
         if (i == 7) begin
            chk("ovf_full",     b2.FULL,         1'b1);
            chk("ovf_pre_ovf",  b2.OVERFLOW,     1'b0);
            chk("ovf_pre_valid", b2.SCALER_VALID, 1'b0);
         end
      end
      b2.WR_EN = 1'b0;
      chk("ovf_set",    b2.OVERFLOW,     1'b1);
      chk("ovf_valid0", b2.SCALER_VALID, 1'b1);
      chk("ovf_data0",  b2.INPUT_SCALER, 34'h1_0000_0000);
      chk("ovf_full_clr", b2.FULL,       1'b0);
      for (int k = 1; k < 8; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         v2 = 34'h1_0000_0000 + 34'(k);
         chk($sformatf("ovf_data%0d", k),  b2.INPUT_SCALER, v2);
         chk($sformatf("ovf_valid%0d", k), b2.SCALER_VALID, 1'b1);
         chk($sformatf("ovf_last%0d", k),  b2.FRAME_LAST,   (k == 7) ? 1'b1 : 1'b0);
      end
      @(posedge CLK);
      @(negedge CLK);
      chk("ovf_end_valid",  b2.SCALER_VALID, 1'b0);
      chk("ovf_end_lreset", b2.LAYER_RESET,  1'b1);
      chk("ovf_sticky",     b2.OVERFLOW,     1'b1);

      // Random gaps, 20 frames through the wrapping buffer
      s0 = n_seen; pushed = 0;
      while (pushed < 20 * FL) begin
         if ($urandom_range(0, 1) == 1) begin
            rv = {2'($urandom_range(0, 3)), 32'($urandom)};
            push1(rv);
            pushed++;
         end else begin
            idle(1);
         end
      end
      idle(10);
      chk("rand_valid_cycles", 64'(n_seen - s0), 64'(20 * FL));

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/input_scaler_feeder.md
Name: input_scaler_feeder

Overview:
- Upstream stage of the linear layer: buffers net-input scalars (unknowns followed by nonlinear terms) from the loader, then streams them one per cycle to the layer's INPUT_SCALER.
- Launches a frame only when a whole frame of FRAME_LEN = NUM_UNKNOWNS + NUM_NONLIN elements is buffered. The layer has no stall input, so a frame, once started, runs without gaps.
- Holds the layer's RESET high while idle, so the layer's weight pointer and accumulators realign with every frame start.

Parameters:
- NUM_UNKNOWNS, 2, number of equation unknowns.
- NUM_NONLIN, 1, number of nonlinear terms per frame.
- BIT_WIDTH, 32, floating point size.
- EXTRA_BITS, 2, Flopoco extra bits; only 0 or 2 allowed.
- FIFO_DEPTH, 8, buffer entries; must be a power of 2 and >= FRAME_LEN.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- WR_EN  in  1  push WR_DATA this cycle.
- WR_DATA  in  BIT_WIDTH+EXTRA_BITS  float scalar to buffer.
- FULL  out  1  high when count == FIFO_DEPTH.
- OVERFLOW  out  1  sticky; set when a push is dropped.
- INPUT_SCALER  out  BIT_WIDTH+EXTRA_BITS  registered scalar to the layer.
- SCALER_VALID  out  1  high when INPUT_SCALER carries a frame element.
- FRAME_LAST  out  1  high with the last element (index FRAME_LEN-1) of a frame.
- LAYER_RESET  out  1  registered reset to the layer; high whenever no frame is streaming.

Behaviour:
- Reset (asynchronous) clears the following:
  - wr_ptr, rd_ptr and count go to 0; state goes to IDLE; elem_idx goes to 0.
  - INPUT_SCALER = 0, SCALER_VALID = 0, FRAME_LAST = 0, FULL = 0, OVERFLOW = 0, LAYER_RESET = 1.
  - Reset mid-frame discards the partial frame and all buffered data.
- count is the number of buffered entries not yet loaded into the output register. Its width is clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Push occurs when WR_EN is high and FULL is low (FULL as registered this cycle). WR_EN while FULL drops the data, leaves the pointers unchanged and sets OVERFLOW, even if a pop happens in the same cycle.
- Pop: at a clock edge, mem[rd_ptr] is loaded into INPUT_SCALER and rd_ptr advances. Pop conditions:
  - IDLE and count >= FRAME_LEN: go to STREAM, elem_idx = 0.
  - STREAM and elem_idx < FRAME_LEN-1: elem_idx increments.
  - STREAM, elem_idx == FRAME_LEN-1 and count >= FRAME_LEN: back-to-back frame, elem_idx = 0, no gap cycle.
- End of stream: STREAM, elem_idx == FRAME_LEN-1 and count < FRAME_LEN. Next state is IDLE; INPUT_SCALER goes to 0, SCALER_VALID to 0 and LAYER_RESET to 1 at that edge.
- On every pop edge: SCALER_VALID = 1 and LAYER_RESET = 0. FRAME_LAST = 1 exactly when the loaded element's index equals FRAME_LEN-1.
- Push and pop in the same cycle: count is unchanged. Pop decisions use the pre-edge count, so a same-cycle push does not count toward launching a frame.
- Latency: the first element appears on INPUT_SCALER one edge after the edge that raised count to FRAME_LEN. Elements then follow one per cycle in write order.
- The layer result for a frame is the layer's concern; this block guarantees exactly FRAME_LEN contiguous valid cycles per frame, each preceded by LAYER_RESET low from its first element.

Test Plan:
- Reset mid-operation: FRAME_LEN=3, DEPTH=8, 2 elements buffered, RESET pulsed asynchronously between edges. Outputs go immediately to their reset values, FIFO is empty, and a subsequent 2-element write produces no launch.
- Single frame: push A,B,C on cycles 0-2.
  - Cycle 3: INPUT_SCALER = A, SCALER_VALID = 1, LAYER_RESET = 0.
  - Cycle 4: B. Cycle 5: C with FRAME_LAST = 1.
  - Cycle 6: SCALER_VALID = 0, INPUT_SCALER = 0, LAYER_RESET = 1.
- Back-to-back: push 6 elements on consecutive cycles. The bench sees 6 contiguous valid cycles in write order, FRAME_LAST on the 3rd and 6th, and LAYER_RESET low throughout.
- Partial frame: push 2 elements only. SCALER_VALID stays 0 and LAYER_RESET stays 1 indefinitely. The 3rd push launches the frame one edge later.
- Overflow: with no pop in progress, push 9 elements into DEPTH 8.
  - Note: 8 buffered elements satisfy the launch condition, so streaming would start at the edge after count reaches FRAME_LEN and the bench would observe count decreasing. To reach FULL with no pop, the bench holds RESET-free state only while count < FRAME_LEN, or runs this scenario with FRAME_LEN = FIFO_DEPTH.
  - With FRAME_LEN = FIFO_DEPTH: FULL = 1 after the 8th push, the 9th push is dropped, OVERFLOW = 1, and the 8 stored values stream out unchanged.
- Wrap-around: stream 20 frames of 3 with random gaps through DEPTH 8. Output order matches input order exactly, with no gaps inside any frame.
